// File: rtl/next_pc_unit.sv
// next_pc_unit
// Next-PC generator with a direct-mapped branch target buffer (BTB).
// Every cycle it predicts the next fetch address from the current PC and
// redirects fetch when EX resolves a mispredicted branch or jump.
//
// Optional feature macro: NPC_PERF_EN adds the br_cnt / mis_cnt counters.
//
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   ClockEnable         global enable; gates all state changes and pc_we
//   stall               hold fetch at pc_q (overridden by flush)
//   pc_q                current PC from the PC register's Q output
//   ex_*                branch/jump resolution from EX plus the prediction
//                       that travelled down the pipeline with it
//   next_pc, pc_we      D input and enable of the PC register
//   pred_taken/_target  BTB prediction for pc_q
//   flush               mispredict redirect; squash IF and ID
//   br_cnt, mis_cnt     resolve / mispredict counters (NPC_PERF_EN only)
module next_pc_unit #(
  parameter int NrOfBits   = 32,
  parameter int BtbEntries = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                stall,
  input  logic [NrOfBits-1:0] pc_q,
  input  logic                ex_valid,
  input  logic [NrOfBits-1:0] ex_pc,
  input  logic                ex_taken,
  input  logic [NrOfBits-1:0] ex_target,
  input  logic                ex_pred_taken,
  input  logic [NrOfBits-1:0] ex_pred_target,
  output logic [NrOfBits-1:0] next_pc,
  output logic                pc_we,
  output logic                pred_taken,
  output logic [NrOfBits-1:0] pred_target,
  output logic                flush
`ifdef NPC_PERF_EN
  ,
  output logic [31:0]         br_cnt,
  output logic [31:0]         mis_cnt
`endif
);

  localparam int IndexBits = $clog2(BtbEntries);
  localparam int TagLsb    = IndexBits + 2;
  localparam int TagBits   = NrOfBits - TagLsb;

  localparam logic [NrOfBits-1:0] PcStep    = NrOfBits'(4);
  localparam logic [NrOfBits-1:0] AlignMask = ~(NrOfBits'(3));

  // BTB storage
  logic [BtbEntries-1:0] valid_q, valid_d;
  logic [TagBits-1:0]    tag_q [BtbEntries];
  logic [TagBits-1:0]    tag_d [BtbEntries];
  logic [NrOfBits-1:0]   tgt_q [BtbEntries];
  logic [NrOfBits-1:0]   tgt_d [BtbEntries];
  logic [1:0]            ctr_q [BtbEntries];
  logic [1:0]            ctr_d [BtbEntries];

  logic [IndexBits-1:0]  lk_idx_s;
  logic [TagBits-1:0]    lk_tag_s;
  logic                  lk_hit_s;
  logic [IndexBits-1:0]  up_idx_s;
  logic [TagBits-1:0]    up_tag_s;
  logic                  up_hit_s;
  logic [NrOfBits-1:0]   next_raw_s;

  assign lk_idx_s = pc_q[IndexBits+1:2];
  assign lk_tag_s = pc_q[NrOfBits-1:TagLsb];
  assign up_idx_s = ex_pc[IndexBits+1:2];
  assign up_tag_s = ex_pc[NrOfBits-1:TagLsb];

  // Lookup on pc_q and the mispredict decision; lookup sees pre-update state.
  always_comb begin
    lk_hit_s    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
    up_hit_s    = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
    pred_taken  = lk_hit_s && ctr_q[lk_idx_s][1];
    if (lk_hit_s) begin
      pred_target = tgt_q[lk_idx_s];
    end else begin
      pred_target = '0;
    end
    flush = ex_valid && ((ex_taken != ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  end

  // next_pc selection: flush > stall > predicted-taken > sequential.
  always_comb begin
    if (flush) begin
      if (ex_taken) begin
        next_raw_s = ex_target;
      end else begin
        next_raw_s = ex_pc + PcStep;
      end
    end else if (stall) begin
      next_raw_s = pc_q;
    end else if (pred_taken) begin
      next_raw_s = pred_target;
    end else begin
      next_raw_s = pc_q + PcStep;
    end
    // Fetch addresses are word aligned.
    next_pc = next_raw_s & AlignMask;
    pc_we   = ClockEnable && (flush || !stall);
  end

  // BTB training from the EX resolution, addressed by ex_pc.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (ClockEnable && ex_valid) begin
      if (up_hit_s) begin
        if (ex_taken) begin
          ctr_d[up_idx_s] = (ctr_q[up_idx_s] == 2'b11) ? 2'b11 : ctr_q[up_idx_s] + 2'b01;
          tgt_d[up_idx_s] = ex_target;
        end else begin
          ctr_d[up_idx_s] = (ctr_q[up_idx_s] == 2'b00) ? 2'b00 : ctr_q[up_idx_s] - 2'b01;
        end
      end else if (ex_taken) begin
        // Allocate over whatever occupied this index, weakly taken.
        valid_d[up_idx_s] = 1'b1;
        tag_d[up_idx_s]   = up_tag_s;
        tgt_d[up_idx_s]   = ex_target;
        ctr_d[up_idx_s]   = 2'b10;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // BTB state registers; reset invalidates every entry.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      for (int i = 0; i < BtbEntries; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b00;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

`ifdef NPC_PERF_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  // Performance counter next-state; both wrap at 2^32.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (ClockEnable) begin
      br_cnt_d  = br_cnt_q + {31'd0, ex_valid};
      mis_cnt_d = mis_cnt_q + {31'd0, flush};
    end else begin
      br_cnt_d  = br_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit (NrOfBits=32, BtbEntries=8).
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the BTB held as plain arrays.
module tb_next_pc_unit;

  logic        Clock = 1'b0;
  logic        Reset, ClockEnable, stall;
  logic [31:0] pc_q, ex_pc, ex_target, ex_pred_target;
  logic        ex_valid, ex_taken, ex_pred_taken;
  logic [31:0] next_pc, pred_target;
  logic        pc_we, pred_taken, flush;
`ifdef NPC_PERF_EN
  logic [31:0] br_cnt, mis_cnt;
`endif

  always #5 Clock = ~Clock;

  next_pc_unit #(.NrOfBits(32), .BtbEntries(8)) dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .stall(stall),
    .pc_q(pc_q), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .next_pc(next_pc), .pc_we(pc_we),
    .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush)
`ifdef NPC_PERF_EN
    , .br_cnt(br_cnt), .mis_cnt(mis_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 8 entries, index = (pc/4) mod 8, tag = pc/32.
  bit          m_valid [8];
  logic [31:0] m_tag   [8];
  logic [31:0] m_tgt   [8];
  int          m_ctr   [8];
  logic [31:0] m_br, m_mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd8);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 32'd32;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_flush();
    return ex_valid && ((ex_taken != ex_pred_taken) ||
                        (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_br  = 32'd0;
    m_mis = 32'd0;
  endtask

  task automatic check_outputs();
    bit          e_hit, e_pt, e_fl, e_we;
    logic [31:0] e_ptgt, e_np;
    e_hit  = m_hit(pc_q);
    e_pt   = e_hit && (m_ctr[idx_of(pc_q)] >= 2);
    e_ptgt = e_hit ? m_tgt[idx_of(pc_q)] : 32'd0;
    e_fl   = m_flush();
    if (e_fl)       e_np = ex_taken ? ex_target : ex_pc + 32'd4;
    else if (stall) e_np = pc_q;
    else if (e_pt)  e_np = e_ptgt;
    else            e_np = pc_q + 32'd4;
    e_np = e_np & ~32'd3;
    e_we = ClockEnable && (e_fl || !stall);
    chk("next_pc", {32'd0, next_pc}, {32'd0, e_np});
    chk("pc_we", {63'd0, pc_we}, {63'd0, e_we});
    chk("pred_taken", {63'd0, pred_taken}, {63'd0, e_pt});
    chk("pred_target", {32'd0, pred_target}, {32'd0, e_ptgt});
    chk("flush", {63'd0, flush}, {63'd0, e_fl});
`ifdef NPC_PERF_EN
    chk("br_cnt", {32'd0, br_cnt}, {32'd0, m_br});
    chk("mis_cnt", {32'd0, mis_cnt}, {32'd0, m_mis});
`endif
  endtask

  // Apply what the clock edge does to the model state.
  task automatic model_edge();
    int i;
    if (!Reset && ClockEnable) begin
      if (ex_valid) m_br = m_br + 32'd1;
      if (m_flush()) m_mis = m_mis + 32'd1;
      if (ex_valid) begin
        i = idx_of(ex_pc);
        if (m_hit(ex_pc)) begin
          if (ex_taken) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = ex_target;
          end else begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (ex_taken) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = tag_of(ex_pc);
          m_tgt[i]   = ex_target;
          m_ctr[i]   = 2;
        end
      end
    end
  endtask

  // Inputs are set just after a negedge; check, then cross one rising edge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
    ex_valid = v; ex_pc = pc; ex_taken = tk;
    ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'h0040_0000 + 32'd4 * 32'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    return t & ~32'd3;
  endfunction

  initial begin
    ClockEnable = 1'b1; stall = 1'b0; pc_q = 32'h0040_0000;
    set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    Reset = 1'b1;
    model_reset();

    // Cold BTB in reset.
    #1;
    chk("rst_next_pc", {32'd0, next_pc}, {32'd0, 32'h0040_0004});
    chk("rst_pc_we", {63'd0, pc_we}, 64'd1);
    chk("rst_pred", {63'd0, pred_taken}, 64'd0);
    step();
    Reset = 1'b0;

    // Taken branch, predicted not taken: redirect and allocate.
    set_ex(1'b1, 32'h0040_0008, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
    #1;
    chk("alloc_flush", {63'd0, flush}, 64'd1);
    chk("alloc_next", {32'd0, next_pc}, {32'd0, 32'h0040_0040});
    step();
    set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    pc_q = 32'h0040_0008;
    #1;
    chk("hit_pred", {63'd0, pred_taken}, 64'd1);
    chk("hit_tgt", {32'd0, pred_target}, {32'd0, 32'h0040_0040});
    step();

    // Two not-taken resolves: 10 -> 01 -> 00, entry stays valid.
    set_ex(1'b1, 32'h0040_0008, 1'b0, 32'd0, 1'b1, 32'h0040_0040);
    step();
    step();
    set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    chk("nt_pred", {63'd0, pred_taken}, 64'd0);
    chk("nt_still_valid", {32'd0, pred_target}, {32'd0, 32'h0040_0040});
    step();
    set_ex(1'b1, 32'h0040_0008, 1'b1, 32'h0040_0040, 1'b0, 32'd0);
    step();
    set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    chk("ctr01_pred", {63'd0, pred_taken}, 64'd0);
    step();

    // Stall with flush, then stall alone.
    stall = 1'b1;
    set_ex(1'b1, 32'h0040_0010, 1'b0, 32'd0, 1'b1, 32'h0040_0080);
    #1;
    chk("stall_flush_we", {63'd0, pc_we}, 64'd1);
    chk("stall_flush_next", {32'd0, next_pc}, {32'd0, 32'h0040_0014});
    step();
    set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    chk("stall_we", {63'd0, pc_we}, 64'd0);
    chk("stall_next", {32'd0, next_pc}, {32'd0, 32'h0040_0008});
    step();
    stall = 1'b0;

    // Aliasing: 0x..28 shares index 2 with 0x..08.
    set_ex(1'b1, 32'h0040_0028, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
    step();
    set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    chk("alias_miss", {63'd0, pred_taken}, 64'd0);
    chk("alias_tgt", {32'd0, pred_target}, 64'd0);
    step();
    pc_q = 32'h0040_0028;
    step();

    // Wrap.
    pc_q = 32'hFFFF_FFFC;
    #1;
    chk("wrap", {32'd0, next_pc}, 64'd0);
    step();

    // Asynchronous reset mid-run: BTB misses immediately.
    pc_q = 32'h0040_0028;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_miss", {63'd0, pred_taken}, 64'd0);
    chk("midrst_next", {32'd0, next_pc}, {32'd0, 32'h0040_002C});
`ifdef NPC_PERF_EN
    chk("midrst_br", {32'd0, br_cnt}, 64'd0);
    chk("midrst_mis", {32'd0, mis_cnt}, 64'd0);
`endif
    step();
    Reset = 1'b0;

    // Five resolves, two mispredicts.
    set_ex(1'b1, 32'h0040_0030, 1'b1, 32'h0040_0200, 1'b0, 32'd0);           step();
    set_ex(1'b1, 32'h0040_0030, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);   step();
    set_ex(1'b1, 32'h0040_0034, 1'b0, 32'd0, 1'b0, 32'd0);                   step();
    set_ex(1'b1, 32'h0040_0038, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0304);   step();
    set_ex(1'b1, 32'h0040_003C, 1'b0, 32'd0, 1'b0, 32'd0);                   step();
    set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef NPC_PERF_EN
    #1;
    chk("perf_br", {32'd0, br_cnt}, 64'd5);
    chk("perf_mis", {32'd0, mis_cnt}, 64'd2);
`endif
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] tg;
      ClockEnable = ($urandom_range(0, 9) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      pc_q        = rand_pc();
      tg          = rand_tgt();
      set_ex($urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 1) == 1, tg,
             $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? tg : rand_tgt());
      if (n == 200) begin
        Reset = 1'b1;
        model_reset();
      end
      step();
      Reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
